pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  Merges the RAW stall from hazard detection, taken branch/jump redirects from
//  EX, multi-cycle data-memory waits and HALT. Drives PC and per-stage register
//  enables, bubble/flush controls, a halted flag and a stall-cycle counter.
// PARAMETERS
//  DRAIN_CYCLES  3   cycles after HALT leaves ID before halted is asserted
//  CNT_W         16  width of stall_cnt (saturating)
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst          in   1      synchronous reset, active-low
//  hzd_stall    in   1      RAW stall request from hazard detection (ID vs EX/MEM/WB)
//  br_taken_ex  in   1      branch/jump in EX resolved taken; PC mux selects target
//  dmem_stall   in   1      data memory busy this cycle (load/store not finished)
//  dmem_done    in   1      data memory access completes this cycle
//  halt_id      in   1      HALT instruction decoded in ID
//  pc_we        out  1      PC register write enable
//  ifid_we      out  1      IF/ID pipeline register write enable
//  idex_we      out  1      ID/EX write enable
//  exmem_we     out  1      EX/MEM write enable
//  memwb_we     out  1      MEM/WB write enable
//  ifid_flush   out  1      load NOP into IF/ID (needs ifid_we=1)
//  idex_bubble  out  1      load NOP into ID/EX (regWrite/memRead/memWrite=0)
//  halted       out  1      registered; processor stopped
//  stall_cnt    out  CNT_W  cycles with pc_we=0 while not halted (saturating)
// BEHAVIOUR
//  Reset (rst=0 at edge): state=RUN, drain_cnt=0, halted=0, stall_cnt=0.
//   While rst=0, outputs: pc_we=0, all stage we=1, ifid_flush=1, idex_bubble=1.
//  FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Outputs are Mealy (same cycle).
//  RUN, priority high->low:
//   1 dmem_stall & ~dmem_done: all we=0, no flush/bubble; next=MEM_WAIT.
//   2 br_taken_ex: pc_we=1, all we=1, ifid_flush=1, idex_bubble=1
//     (HALT in ID is wrong-path, ignored).
//   3 hzd_stall: pc_we=0, ifid_we=0, idex_bubble=1, others we=1
//     (HALT in ID waits until the stall clears).
//   4 halt_id: pc_we=0, ifid_flush=1, stage we=1; drain_cnt<=DRAIN_CYCLES-1;
//     next=DRAIN.
//   5 else: all we=1, no flush/bubble.
//  MEM_WAIT: all we=0 each cycle until dmem_done=1. On the dmem_done cycle the
//   pipeline still freezes; next=RUN. dmem_stall & dmem_done in one cycle = done.
//  DRAIN: pc_we=0, ifid_flush=1, idex_bubble=1. exmem_we=memwb_we=1 unless
//   dmem_stall (then all we=0, drain_cnt holds). drain_cnt decrements on each
//   non-stalled cycle. At 0 with no stall: next=HALTED, halted<=1.
//   br_taken_ex is ignored in DRAIN (no branch remains in EX).
//  HALTED: all we=0, no flush/bubble, halted=1. Leaves only on reset.
//  stall_cnt: +1 in any non-HALTED cycle with pc_we=0 and rst=1. Holds at
//   2^CNT_W-1. DRAIN cycles count.
//  Reset mid-MEM_WAIT or DRAIN: abandon and go to RUN; no pending state kept.
//  Invariant: ifid_flush=1 implies ifid_we=1. idex_bubble=1 implies idex_we=1.
// TESTING
//  T1 reset: rst=0 2 cycles, then 1 with all in=0 -> pc_we=1, stage we=1,
//     halted=0, stall_cnt=0.
//  T2 RAW: hzd_stall=1 for 2 cycles -> pc_we=0, ifid_we=0, idex_bubble=1 both
//     cycles; stall_cnt=2.
//  T3 mem wait: dmem_stall=1 for 3 cycles, dmem_done on 3rd -> all we=0 for 3
//     cycles, RUN on 4th; stall_cnt=3.
//  T4 branch vs stall: br_taken_ex=1, hzd_stall=1, halt_id=1 together ->
//     pc_we=1, ifid_flush=1, idex_bubble=1; state stays RUN.
//  T5 halt: halt_id=1, DRAIN_CYCLES=3, dmem_stall=1 on 2nd drain cycle ->
//     halted=1 after 4 drained cycles + 1 stall cycle; then all we=0.
//  T6 saturation/reset: CNT_W=2, hzd_stall held 6 cycles -> stall_cnt=3;
//     rst=0 during DRAIN -> RUN, halted=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
// Merges RAW stalls, EX redirects, data-memory waits and HALT into PC and
// per-stage enables, NOP-injection controls, a halted flag and a stall counter.
// Enables and flush/bubble controls are Mealy outputs; halted and stall_cnt
// are registered.
module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hzd_stall,
  input  logic             br_taken_ex,
  input  logic             dmem_stall,
  input  logic             dmem_done,
  input  logic             halt_id,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  // Drain counter only has to hold DRAIN_CYCLES-1 down to 0.
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } ctrlState_t;

  ctrlState_t          state;
  ctrlState_t          nextState;
  logic [DRAIN_W-1:0]  drainCnt;
  logic [DRAIN_W-1:0]  drainNext;
  logic                haltedQ;
  logic                haltedNext;
  logic [CNT_W-1:0]    stallCnt;
  logic                memBusy;

  // A memory access finishing this cycle is never treated as a stall.
  assign memBusy = dmem_stall & ~dmem_done;

  // Next-state and same-cycle control decode; reset overrides everything.
  always_comb begin
    nextState   = state;
    drainNext   = drainCnt;
    haltedNext  = haltedQ;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    unique case (state)
      RUN: begin
        if (memBusy) begin
          // Whole pipeline freezes until memory completes.
          nextState = MEM_WAIT;
        end else if (br_taken_ex) begin
          // Redirect: squash the two younger wrong-path instructions.
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          idex_we     = 1'b1;
          exmem_we    = 1'b1;
          memwb_we    = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (hzd_stall) begin
          // Hold IF and ID, let older instructions advance behind a bubble.
          idex_we     = 1'b1;
          exmem_we    = 1'b1;
          memwb_we    = 1'b1;
          idex_bubble = 1'b1;
        end else if (halt_id) begin
          // HALT proceeds down the pipe; nothing new is fetched behind it.
          ifid_we    = 1'b1;
          idex_we    = 1'b1;
          exmem_we   = 1'b1;
          memwb_we   = 1'b1;
          ifid_flush = 1'b1;
          drainNext  = DRAIN_LOAD;
          nextState  = DRAIN;
        end else begin
          pc_we    = 1'b1;
          ifid_we  = 1'b1;
          idex_we  = 1'b1;
          exmem_we = 1'b1;
          memwb_we = 1'b1;
        end
      end

      MEM_WAIT: begin
        // Frozen through the completing cycle as well.
        if (dmem_done) begin
          nextState = RUN;
        end
      end

      DRAIN: begin
        // Memory stall freezes the drain; flush/bubble drop with their enables.
        if (!memBusy) begin
          ifid_we     = 1'b1;
          idex_we     = 1'b1;
          exmem_we    = 1'b1;
          memwb_we    = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (drainCnt == '0) begin
            nextState  = HALTED;
            haltedNext = 1'b1;
          end else begin
            drainNext = drainCnt - DRAIN_W'(1);
          end
        end
      end

      HALTED: begin
        haltedNext = 1'b1;
      end

      default: begin
        nextState = RUN;
      end
    endcase

    if (!rst) begin
      nextState   = RUN;
      drainNext   = '0;
      haltedNext  = 1'b0;
      pc_we       = 1'b0;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  // State, drain counter, halted flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      drainCnt <= '0;
      haltedQ  <= 1'b0;
      stallCnt <= '0;
    end else begin
      state    <= nextState;
      drainCnt <= drainNext;
      haltedQ  <= haltedNext;
      if ((state != HALTED) && !pc_we && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
    end
  end

  assign halted    = haltedQ;
  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, RAW stall, memory wait, branch
// priority, HALT drain with a memory stall, counter saturation and reset
// out of DRAIN.
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  logic hzd_stall, br_taken_ex, dmem_stall, dmem_done, halt_id;

  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble, halted;
  logic [15:0] stall_cnt;

  logic sPcWe, sIfidWe, sIdexWe, sExmemWe, sMemwbWe, sIfidFlush, sIdexBubble, sHalted;
  logic [1:0] sStallCnt;

  int checks;
  int failures;

  // {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble}
  localparam logic [6:0] O_RUN    = 7'b1111100;
  localparam logic [6:0] O_FREEZE = 7'b0000000;
  localparam logic [6:0] O_RST    = 7'b0111111;
  localparam logic [6:0] O_BR     = 7'b1111111;
  localparam logic [6:0] O_HZD    = 7'b0011101;
  localparam logic [6:0] O_HALT   = 7'b0111110;
  localparam logic [6:0] O_DRAIN  = 7'b0111111;

  logic [6:0] outs;
  logic [6:0] satOuts;
  assign outs    = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble};
  assign satOuts = {sPcWe, sIfidWe, sIdexWe, sExmemWe, sMemwbWe, sIfidFlush, sIdexBubble};

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hzd_stall(hzd_stall), .br_taken_ex(br_taken_ex),
    .dmem_stall(dmem_stall), .dmem_done(dmem_done), .halt_id(halt_id),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .memwb_we(memwb_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .hzd_stall(hzd_stall), .br_taken_ex(br_taken_ex),
    .dmem_stall(dmem_stall), .dmem_done(dmem_done), .halt_id(halt_id),
    .pc_we(sPcWe), .ifid_we(sIfidWe), .idex_we(sIdexWe), .exmem_we(sExmemWe),
    .memwb_we(sMemwbWe), .ifid_flush(sIfidFlush), .idex_bubble(sIdexBubble),
    .halted(sHalted), .stall_cnt(sStallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, then let Mealy outputs settle.
  task automatic step(input logic h, input logic b, input logic ds, input logic dd, input logic hl);
    @(negedge clk);
    hzd_stall   = h;
    br_taken_ex = b;
    dmem_stall  = ds;
    dmem_done   = dd;
    halt_id     = hl;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (outs !== O_RST) begin failures++; $display("FAIL reset_outs_c1 got=%b exp=%b", outs, O_RST); end
    step(0, 0, 0, 0, 0);
    checks++; if (outs !== O_RST) begin failures++; $display("FAIL reset_outs_c2 got=%b exp=%b", outs, O_RST); end
    @(posedge clk); #1;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (outs !== O_RUN) begin failures++; $display("FAIL reset_release_outs got=%b exp=%b", outs, O_RUN); end
    @(posedge clk); #1;
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_release_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_release_halted got=%b exp=0", halted); end
  endtask

  task automatic test_raw;
    step(1, 0, 0, 0, 0);
    checks++; if (outs !== O_HZD) begin failures++; $display("FAIL raw_c1 got=%b exp=%b", outs, O_HZD); end
    step(1, 0, 0, 0, 0);
    checks++; if (outs !== O_HZD) begin failures++; $display("FAIL raw_c2 got=%b exp=%b", outs, O_HZD); end
    step(0, 0, 0, 0, 0);
    checks++; if (outs !== O_RUN) begin failures++; $display("FAIL raw_after got=%b exp=%b", outs, O_RUN); end
    checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL raw_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_mem_wait;
    step(0, 0, 1, 0, 0);
    checks++; if (outs !== O_FREEZE) begin failures++; $display("FAIL mem_c1 got=%b exp=%b", outs, O_FREEZE); end
    step(0, 1, 1, 0, 0);
    checks++; if (outs !== O_FREEZE) begin failures++; $display("FAIL mem_c2_br_ignored got=%b exp=%b", outs, O_FREEZE); end
    step(0, 0, 1, 1, 0);
    checks++; if (outs !== O_FREEZE) begin failures++; $display("FAIL mem_done_cycle got=%b exp=%b", outs, O_FREEZE); end
    step(0, 0, 0, 0, 0);
    checks++; if (outs !== O_RUN) begin failures++; $display("FAIL mem_resume got=%b exp=%b", outs, O_RUN); end
    checks++; if (stall_cnt !== 16'd5) begin failures++; $display("FAIL mem_cnt got=%0d exp=5", stall_cnt); end
  endtask

  task automatic test_branch;
    step(1, 1, 0, 0, 1);
    checks++; if (outs !== O_BR) begin failures++; $display("FAIL br_priority got=%b exp=%b", outs, O_BR); end
    step(0, 0, 0, 0, 0);
    checks++; if (outs !== O_RUN) begin failures++; $display("FAIL br_stays_run got=%b exp=%b", outs, O_RUN); end
    step(0, 1, 1, 0, 0);
    checks++; if (outs !== O_FREEZE) begin failures++; $display("FAIL br_vs_mem got=%b exp=%b", outs, O_FREEZE); end
    step(0, 0, 0, 1, 0);
    checks++; if (outs !== O_FREEZE) begin failures++; $display("FAIL br_mem_done got=%b exp=%b", outs, O_FREEZE); end
    step(1, 0, 0, 0, 1);
    checks++; if (outs !== O_HZD) begin failures++; $display("FAIL hzd_over_halt got=%b exp=%b", outs, O_HZD); end
    step(0, 0, 0, 0, 0);
    checks++; if (outs !== O_RUN) begin failures++; $display("FAIL hzd_halt_no_drain got=%b exp=%b", outs, O_RUN); end
    checks++; if (stall_cnt !== 16'd8) begin failures++; $display("FAIL br_cnt got=%0d exp=8", stall_cnt); end
  endtask

  task automatic test_halt;
    step(0, 0, 0, 0, 1);
    checks++; if (outs !== O_HALT) begin failures++; $display("FAIL halt_enter got=%b exp=%b", outs, O_HALT); end
    step(0, 0, 0, 0, 0);
    checks++; if (outs !== O_DRAIN) begin failures++; $display("FAIL drain_c1 got=%b exp=%b", outs, O_DRAIN); end
    step(0, 0, 1, 0, 0);
    checks++; if (outs !== O_FREEZE) begin failures++; $display("FAIL drain_mem_stall got=%b exp=%b", outs, O_FREEZE); end
    step(0, 1, 0, 0, 0);
    checks++; if (outs !== O_DRAIN) begin failures++; $display("FAIL drain_c2_br_ignored got=%b exp=%b", outs, O_DRAIN); end
    step(0, 0, 0, 0, 0);
    checks++; if (outs !== O_DRAIN) begin failures++; $display("FAIL drain_c3 got=%b exp=%b", outs, O_DRAIN); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halted_early got=%b exp=0", halted); end
    step(0, 0, 0, 0, 0);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halted_set got=%b exp=1", halted); end
    checks++; if (outs !== O_FREEZE) begin failures++; $display("FAIL halted_outs got=%b exp=%b", outs, O_FREEZE); end
    checks++; if (stall_cnt !== 16'd13) begin failures++; $display("FAIL halt_cnt got=%0d exp=13", stall_cnt); end
    step(1, 1, 0, 0, 1);
    checks++; if (outs !== O_FREEZE) begin failures++; $display("FAIL halted_ignores_in got=%b exp=%b", outs, O_FREEZE); end
    step(0, 0, 0, 0, 0);
    checks++; if (stall_cnt !== 16'd13) begin failures++; $display("FAIL halted_cnt_hold got=%0d exp=13", stall_cnt); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halted_sticky got=%b exp=1", halted); end
  endtask

  task automatic test_saturation_reset;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_from_halted got=%b exp=0", halted); end
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++; if (sStallCnt !== 2'd3) begin failures++; $display("FAIL sat_cnt got=%0d exp=3", sStallCnt); end
    checks++; if (stall_cnt !== 16'd6) begin failures++; $display("FAIL wide_cnt got=%0d exp=6", stall_cnt); end
    checks++; if (satOuts !== O_RUN) begin failures++; $display("FAIL sat_outs got=%b exp=%b", satOuts, O_RUN); end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    checks++; if (outs !== O_DRAIN) begin failures++; $display("FAIL pre_reset_drain got=%b exp=%b", outs, O_DRAIN); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (outs !== O_RST) begin failures++; $display("FAIL drain_reset_outs got=%b exp=%b", outs, O_RST); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (outs !== O_RUN) begin failures++; $display("FAIL drain_reset_run got=%b exp=%b", outs, O_RUN); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL drain_reset_cnt got=%0d exp=0", stall_cnt); end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL drain_abandoned got=%b exp=0", halted); end
    checks++; if (outs !== O_RUN) begin failures++; $display("FAIL drain_abandoned_outs got=%b exp=%b", outs, O_RUN); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    hzd_stall   = 1'b0;
    br_taken_ex = 1'b0;
    dmem_stall  = 1'b0;
    dmem_done   = 1'b0;
    halt_id     = 1'b0;
    test_reset();
    test_raw();
    test_mem_wait();
    test_branch();
    test_halt();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
